// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache <-> embedded memory path.
// Used by the burst controller and the memory test harness.
package cache_mem_pkg;

  localparam int MEM_BW_ADDR = 16;

  localparam logic REQ_READ  = 1'b0;
  localparam logic REQ_WRITE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_READ_LAST,
    ST_WRITE
  } state_e;

endpackage

// File: rtl/memory_embedded_burst_ctrl.sv
// Block read/write burst controller for the single-port embedded memory.
// Reads stream out two cycles after issue; writes use valid/ready.
module memory_embedded_burst_ctrl
  import cache_mem_pkg::*;
#(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = MEM_BW_ADDR,
  parameter int N_BURST = 4
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               req_i,
  input  logic               req_rw_i,
  input  logic [BW_ADDR-1:0] req_addr_i,
  output logic               ready_o,
  input  logic [BW_DATA-1:0] wdata_i,
  input  logic               wdata_valid_i,
  output logic               wdata_ready_o,
  output logic [BW_DATA-1:0] rdata_o,
  output logic               rdata_valid_o,
  output logic               done_o,
  output logic               mem_wren_o,
  output logic [BW_ADDR-1:0] mem_addr_o,
  output logic [BW_DATA-1:0] mem_data_o,
  input  logic [BW_DATA-1:0] mem_data_i
);

  localparam int BW_BURST =
    (N_BURST > 1) ? $clog2(N_BURST) : 1;
  localparam logic [BW_BURST-1:0] LAST_BEAT =
    BW_BURST'(N_BURST - 1);

  state_e               state_q, state_d;
  logic [BW_BURST-1:0]  beat_q, beat_d;
  logic [BW_ADDR-1:0]   base_q, base_d;
  logic                 rd_pipe_q, rd_pipe_d;
  logic [BW_DATA-1:0]   rdata_q, rdata_d;
  logic                 rdata_valid_q, rdata_valid_d;
  logic                 done_q, done_d;
  logic                 wr_hs;

  assign wr_hs = (state_q == ST_WRITE) && wdata_valid_i;

  // Next-state: sequencing of beats; the beat counter stops on the
  // last beat so the address output holds the last issued address.
  always_comb begin
    state_d       = state_q;
    beat_d        = beat_q;
    base_d        = base_q;
    rd_pipe_d     = (state_q == ST_READ);
    rdata_valid_d = rd_pipe_q;
    rdata_d       = rd_pipe_q ? mem_data_i : rdata_q;
    done_d        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          base_d = req_addr_i;
          beat_d = '0;
          unique case (req_rw_i)
            REQ_READ:  state_d = ST_READ;
            REQ_WRITE: state_d = ST_WRITE;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_READ: begin
        if (beat_q == LAST_BEAT) begin
          state_d = ST_READ_LAST;
        end else begin
          beat_d = beat_q + BW_BURST'(1);
        end
      end
      ST_READ_LAST: begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
      ST_WRITE: begin
        if (wdata_valid_i) begin
          if (beat_q == LAST_BEAT) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d = beat_q + BW_BURST'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset abandons any burst.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      beat_q        <= '0;
      base_q        <= '0;
      rd_pipe_q     <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      base_q        <= base_d;
      rd_pipe_q     <= rd_pipe_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
      done_q        <= done_d;
    end
  end

  assign ready_o       = (state_q == ST_IDLE);
  assign wdata_ready_o = (state_q == ST_WRITE);
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rdata_valid_q;
  assign done_o        = done_q;
  assign mem_wren_o    = wr_hs;
  assign mem_data_o    = wr_hs ? wdata_i : '0;
  assign mem_addr_o    = base_q + BW_ADDR'(beat_q);

endmodule

// File: tb/tb_memory_embedded_burst_ctrl.sv
// Bench for the burst controller with a behavioural memory attached.
// Table of block transfers plus a mid-burst reset sequence.
module tb_memory_embedded_burst_ctrl;

  typedef struct packed {
    logic             rw;
    logic             toggle;
    logic             inject;
    logic [15:0]      addr;
    logic [3:0][31:0] d;
    logic [3:0][15:0] a;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, req_rw;
  logic [15:0] req_addr;
  logic        ready;
  logic [31:0] wdata;
  logic        wdata_valid, wdata_ready;
  logic [31:0] rdata;
  logic        rdata_valid, done;
  logic        mem_wren;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic [31:0] mem [0:65535];
  logic [15:0] maddr_r;
  logic        pl_we;
  logic [15:0] pl_a;
  logic [31:0] pl_d;

  int checks = 0;
  int failures = 0;
  vec_t vecs [7];

  always #5 clk = ~clk;

  memory_embedded_burst_ctrl dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .req_i         (req),
    .req_rw_i      (req_rw),
    .req_addr_i    (req_addr),
    .ready_o       (ready),
    .wdata_i       (wdata),
    .wdata_valid_i (wdata_valid),
    .wdata_ready_o (wdata_ready),
    .rdata_o       (rdata),
    .rdata_valid_o (rdata_valid),
    .done_o        (done),
    .mem_wren_o    (mem_wren),
    .mem_addr_o    (mem_addr),
    .mem_data_o    (mem_wdata),
    .mem_data_i    (mem_rdata)
  );

  // Memory: registered address, unregistered output.
  always @(posedge clk) begin
    if (pl_we) mem[pl_a] <= pl_d;
    else if (mem_wren) mem[mem_addr] <= mem_wdata;
    maddr_r <= mem_addr;
  end
  assign mem_rdata = mem[maddr_r];

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic rw, input logic tog, input logic inj,
    input logic [15:0] addr,
    input logic [31:0] d0, input logic [31:0] d1,
    input logic [31:0] d2, input logic [31:0] d3,
    input logic [15:0] a0, input logic [15:0] a1,
    input logic [15:0] a2, input logic [15:0] a3);
    vec_t v;
    v.rw = rw; v.toggle = tog; v.inject = inj;
    v.addr = addr;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    return v;
  endfunction

  task automatic preload(input logic [15:0] a,
                         input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int beat;
    logic fin;
    @(negedge clk);
    #1 chk("idle_ready", {31'd0, ready}, 32'd1);
    req = 1'b1; req_rw = v.rw; req_addr = v.addr;
    @(negedge clk);
    req = 1'b0;
    if (!v.rw) begin
      for (int c = 0; c < 9; c++) begin
        if (c > 0) @(negedge clk);
        if (v.inject && c == 1) begin
          req = 1'b1; req_rw = 1'b1; req_addr = 16'h0300;
        end else begin
          req = 1'b0;
        end
        #1;
        chk("rd_ready", {31'd0, ready}, {31'd0, c >= 5});
        chk("rd_valid", {31'd0, rdata_valid},
            {31'd0, c >= 2 && c <= 5});
        chk("rd_done", {31'd0, done}, {31'd0, c == 5});
        chk("rd_wren", {31'd0, mem_wren}, 32'd0);
        if (c <= 3)
          chk("rd_addr", {16'd0, mem_addr}, {16'd0, v.a[c]});
        if (c >= 2 && c <= 5)
          chk("rd_data", rdata, v.d[c-2]);
      end
    end else begin
      beat = 0;
      fin = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (c > 0) @(negedge clk);
        if (beat < 4) begin
          wdata_valid = v.toggle ? ((c % 2) == 0) : 1'b1;
          wdata = v.d[beat];
        end else begin
          wdata_valid = 1'b0;
        end
        #1;
        if (beat == 4) begin
          chk("wr_done", {31'd0, done}, 32'd1);
          chk("wr_ready_end", {31'd0, ready}, 32'd1);
          fin = 1'b1;
          break;
        end
        chk("wr_done_early", {31'd0, done}, 32'd0);
        chk("wr_wready", {31'd0, wdata_ready}, 32'd1);
        chk("wr_wren", {31'd0, mem_wren},
            {31'd0, wdata_valid});
        if (wdata_valid) begin
          chk("wr_addr", {16'd0, mem_addr}, {16'd0, v.a[beat]});
          chk("wr_data", mem_wdata, v.d[beat]);
          beat++;
        end
      end
      chk("wr_timeout", {31'd0, fin}, 32'd1);
      wdata_valid = 1'b0;
      @(negedge clk);
      #1 chk("wr_done_pulse", {31'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; req_rw = 1'b0; req_addr = '0;
    wdata = '0; wdata_valid = 1'b0;
    pl_we = 1'b0; pl_a = '0; pl_d = '0;

    vecs[0] = mk(0, 0, 0, 16'h0100,
                 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                 16'h0100, 16'h0101, 16'h0102, 16'h0103);
    vecs[1] = mk(1, 0, 0, 16'h0200,
                 32'h11, 32'h22, 32'h33, 32'h44,
                 16'h0200, 16'h0201, 16'h0202, 16'h0203);
    vecs[2] = mk(0, 0, 0, 16'h0200,
                 32'h11, 32'h22, 32'h33, 32'h44,
                 16'h0200, 16'h0201, 16'h0202, 16'h0203);
    vecs[3] = mk(1, 1, 0, 16'h0300,
                 32'h55, 32'h66, 32'h77, 32'h88,
                 16'h0300, 16'h0301, 16'h0302, 16'h0303);
    vecs[4] = mk(0, 0, 0, 16'h0300,
                 32'h55, 32'h66, 32'h77, 32'h88,
                 16'h0300, 16'h0301, 16'h0302, 16'h0303);
    vecs[5] = mk(0, 0, 0, 16'hFFFE,
                 32'hE0, 32'hE1, 32'hE2, 32'hE3,
                 16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001);
    vecs[6] = mk(0, 0, 1, 16'h0100,
                 32'hA0, 32'hA1, 32'hA2, 32'hA3,
                 16'h0100, 16'h0101, 16'h0102, 16'h0103);

    for (int i = 0; i < 4; i++) begin
      preload(16'h0100 + 16'(i), 32'hA0 + 32'(i));
      preload(16'hFFFE + 16'(i), 32'hE0 + 32'(i));
      preload(16'h0400 + 16'(i), 32'hF0 + 32'(i));
    end

    @(negedge clk);
    #1;
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_wready", {31'd0, wdata_ready}, 32'd0);
    chk("rst_valid", {31'd0, rdata_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wren", {31'd0, mem_wren}, 32'd0);
    chk("rst_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    @(negedge clk);
    req = 1'b1; req_rw = 1'b1; req_addr = 16'h0400;
    @(negedge clk);
    req = 1'b0; wdata_valid = 1'b1; wdata = 32'hC0;
    #1 chk("mr_wren0", {31'd0, mem_wren}, 32'd1);
    @(negedge clk);
    wdata = 32'hC1;
    #1 chk("mr_addr1", {16'd0, mem_addr}, 32'h0401);
    @(negedge clk);
    wdata = 32'hC2;
    #1 chk("mr_wren2", {31'd0, mem_wren}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mr_wren_async", {31'd0, mem_wren}, 32'd0);
    chk("mr_ready_async", {31'd0, ready}, 32'd1);
    chk("mr_wready_async", {31'd0, wdata_ready}, 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk("mr_done", {31'd0, done}, 32'd0);
      chk("mr_wren", {31'd0, mem_wren}, 32'd0);
    end
    wdata_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    #1 chk("mr_done_after", {31'd0, done}, 32'd0);
    run_vec(mk(0, 0, 0, 16'h0400,
               32'hC0, 32'hC1, 32'hF2, 32'hF3,
               16'h0400, 16'h0401, 16'h0402, 16'h0403));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
